// File: rtl/trade_report_packetizer_pkg.sv
// trade_report_packetizer_pkg
// Shared definitions for the trade report packetizer: the packet header
// magic byte and the packetizer FSM state encodings.
// The SEQ state only exists when PKT_SEQ_EN is defined.
package trade_report_packetizer_pkg;

  localparam logic [7:0] HDR_MAGIC = 8'hC3;

`ifdef PKT_SEQ_EN
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HDR     = 2'd1,
    ST_SEQ     = 2'd2,
    ST_PAYLOAD = 2'd3
  } pkt_state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HDR     = 2'd1,
    ST_PAYLOAD = 2'd3
  } pkt_state_t;
`endif

endpackage

// File: rtl/trade_report_packetizer_sync_fifo.sv
// sync_fifo
// Single-clock FIFO with a registered read port and an occupancy output.
// Ports:
//   clk, rst            - clock, synchronous active-high reset (empties FIFO)
//   wr_en, wr_data      - write strobe and data (ignored when full)
//   rd_en               - pop request (ignored when empty); data appears on
//                         rd_data the cycle after the pop and then holds
//   rd_data             - registered read data
//   level               - number of stored words, 0..DEPTH
// DEPTH must be a power of two (at least 2) so the pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LV_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic [WIDTH-1:0] r_rd_data;
  logic             w_do_wr;
  logic             w_do_rd;

  assign w_do_wr = wr_en && (r_level != LV_FULL);
  assign w_do_rd = rd_en && (r_level != '0);
  assign rd_data = r_rd_data;
  assign level   = r_level;

  // Storage array carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (w_do_wr) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  // Pointer, level and read-register update. A pop and a push in the same
  // cycle leave the level unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_level   <= '0;
      r_rd_data <= '0;
    end else begin
      if (w_do_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_rd) begin
        r_rd_ptr  <= r_rd_ptr + 1'b1;
        r_rd_data <= r_mem[r_rd_ptr];
      end
      if (w_do_wr && !w_do_rd) begin
        r_level <= r_level + 1'b1;
      end else if (!w_do_wr && w_do_rd) begin
        r_level <= r_level - 1'b1;
      end
    end
  end

endmodule

// File: rtl/trade_report_packetizer.sv
// trade_report_packetizer
// Buffers trade report words and emits them as stream packets:
// header {C3, 00, 00, len}, optional sequence-number word, then len words.
// A packet starts when MAX_WORDS are buffered or when buffered words have
// waited TIMEOUT_CYCLES in IDLE.
// Optional feature macro: PKT_SEQ_EN (adds the sequence-number word).
// Ports:
//   clk, rst                     - clock, synchronous active-high reset
//   trade_valid, trade_info      - input word strobe (no backpressure)
//   m_tvalid, m_tdata, m_tlast   - output stream
//   m_tready                     - output stream accept
//   overflow                     - sticky, set when an input word is dropped
//   drop_count                   - saturating count of dropped words
module trade_report_packetizer
  import trade_report_packetizer_pkg::*;
#(
  parameter int MAX_WORDS      = 16,
  parameter int FIFO_DEPTH     = 64,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        trade_valid,
  input  logic [31:0] trade_info,
  output logic        m_tvalid,
  output logic [31:0] m_tdata,
  output logic        m_tlast,
  input  logic        m_tready,
  output logic        overflow,
  output logic [15:0] drop_count
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [LW-1:0] LV_FULL    = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0] LV_MAX     = LW'(MAX_WORDS);
  localparam logic [TW-1:0] TIMER_END  = TW'(TIMEOUT_CYCLES - 1);

  pkt_state_t    r_state;
  pkt_state_t    w_next_state;
  logic [7:0]    r_pkt_len;
  logic [7:0]    r_cnt;
  logic [TW-1:0] r_timer;
  logic          r_overflow;
  logic [15:0]   r_drop_count;
`ifdef PKT_SEQ_EN
  logic [31:0]   r_seq_num;
`endif

  logic [LW-1:0] w_level;
  logic          w_fifo_wr;
  logic          w_fifo_rd;
  logic [31:0]   w_fifo_data;
  logic          w_hs;
  logic          w_trigger;

  // Write acceptance looks only at the level at the start of the cycle, so
  // a full FIFO drops the word even if a pop happens in the same cycle.
  assign w_fifo_wr = trade_valid && (w_level != LV_FULL);
  assign w_hs      = m_tvalid && m_tready;
  assign w_trigger = (r_state == ST_IDLE) &&
                     ((w_level >= LV_MAX) ||
                      ((w_level != '0) && (r_timer == TIMER_END)));

  assign overflow   = r_overflow;
  assign drop_count = r_drop_count;

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (w_fifo_wr),
    .wr_data (trade_info),
    .rd_en   (w_fifo_rd),
    .rd_data (w_fifo_data),
    .level   (w_level)
  );

  // Next state and stream outputs. The first payload word is popped on the
  // handshake of the word just before it so the registered FIFO output is
  // ready when PAYLOAD begins; each non-final payload handshake pops the
  // next one. With no pop during a stall, rd_data and m_tdata hold.
  always_comb begin
    w_next_state = r_state;
    m_tvalid     = 1'b0;
    m_tdata      = 32'h0;
    m_tlast      = 1'b0;
    w_fifo_rd    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_trigger) begin
          w_next_state = ST_HDR;
        end
      end
      ST_HDR: begin
        m_tvalid = 1'b1;
        m_tdata  = {HDR_MAGIC, 8'h00, 8'h00, r_pkt_len};
        if (w_hs) begin
`ifdef PKT_SEQ_EN
          w_next_state = ST_SEQ;
`else
          w_next_state = ST_PAYLOAD;
          w_fifo_rd    = 1'b1;
`endif
        end
      end
`ifdef PKT_SEQ_EN
      ST_SEQ: begin
        m_tvalid = 1'b1;
        m_tdata  = r_seq_num;
        if (w_hs) begin
          w_next_state = ST_PAYLOAD;
          w_fifo_rd    = 1'b1;
        end
      end
`endif
      ST_PAYLOAD: begin
        m_tvalid = 1'b1;
        m_tdata  = w_fifo_data;
        m_tlast  = (r_cnt == (r_pkt_len - 8'd1));
        if (w_hs) begin
          if (m_tlast) begin
            w_next_state = ST_IDLE;
          end else begin
            w_fifo_rd = 1'b1;
          end
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // State register, packet length latch, payload counter and flush timer.
  // The timer only runs in IDLE with data waiting and restarts on leaving.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_pkt_len <= '0;
      r_cnt     <= '0;
      r_timer   <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_trigger) begin
        r_pkt_len <= (w_level >= LV_MAX) ? 8'(MAX_WORDS) : 8'(w_level);
      end
      if (r_state != ST_PAYLOAD) begin
        r_cnt <= '0;
      end else if (w_hs) begin
        r_cnt <= r_cnt + 8'd1;
      end
      if ((r_state != ST_IDLE) || (w_level == '0) || w_trigger) begin
        r_timer <= '0;
      end else begin
        r_timer <= r_timer + 1'b1;
      end
    end
  end

  // Drop accounting; the counter sticks at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else if (trade_valid && !w_fifo_wr) begin
      r_overflow <= 1'b1;
      if (r_drop_count != 16'hFFFF) begin
        r_drop_count <= r_drop_count + 16'd1;
      end
    end
  end

`ifdef PKT_SEQ_EN
  // Sequence number advances once per completed packet.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_seq_num <= '0;
    end else if ((r_state == ST_PAYLOAD) && w_hs && m_tlast) begin
      r_seq_num <= r_seq_num + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_trade_report_packetizer.sv
// tb_trade_report_packetizer
// Directed bench for trade_report_packetizer with default parameters.
// Honours PKT_SEQ_EN: when defined, every packet carries a sequence word.
module tb_trade_report_packetizer;

`ifdef PKT_SEQ_EN
  localparam int SEQW = 1;
`else
  localparam int SEQW = 0;
`endif

  logic        clk;
  logic        rst;
  logic        trade_valid;
  logic [31:0] trade_info;
  logic        m_tvalid;
  logic [31:0] m_tdata;
  logic        m_tlast;
  logic        m_tready;
  logic        overflow;
  logic [15:0] drop_count;

  int nCompared   = 0;
  int nMismatched = 0;
  int expSeq      = 0;

  // Accepted stream beats as {tlast, tdata}.
  logic [32:0] gotQ[$];

  trade_report_packetizer dut (
    .clk         (clk),
    .rst         (rst),
    .trade_valid (trade_valid),
    .trade_info  (trade_info),
    .m_tvalid    (m_tvalid),
    .m_tdata     (m_tdata),
    .m_tlast     (m_tlast),
    .m_tready    (m_tready),
    .overflow    (overflow),
    .drop_count  (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every accepted beat as the handshake edge happens.
  always @(posedge clk) begin
    if (!rst && m_tvalid && m_tready) begin
      gotQ.push_back({m_tlast, m_tdata});
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive n one-cycle strobes with values base, base+1, ...
  task automatic applyStimulus(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      trade_valid = 1'b1;
      trade_info  = base + 32'(i);
    end
    @(negedge clk);
    trade_valid = 1'b0;
    trade_info  = 32'h0;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    gotQ.delete();
    expSeq = 0;
  endtask

  task automatic waitBeats(input string tag, input int n, input int budget);
    int k = 0;
    while (gotQ.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    checkOutput(tag, 32'(gotQ.size() >= n), 32'd1);
  endtask

  // Pop and check one packet of n payload words starting at base.
  task automatic checkPacket(input int n, input logic [31:0] base);
    logic [32:0] b;
    checkOutput("beats_avail", 32'(gotQ.size() >= n + 1 + SEQW), 32'd1);
    if (gotQ.size() < n + 1 + SEQW) return;
    b = gotQ.pop_front();
    checkOutput("hdr_data", b[31:0], {8'hC3, 16'h0000, 8'(n)});
    checkOutput("hdr_last", 32'(b[32]), 32'd0);
`ifdef PKT_SEQ_EN
    b = gotQ.pop_front();
    checkOutput("seq_data", b[31:0], 32'(expSeq));
    checkOutput("seq_last", 32'(b[32]), 32'd0);
`endif
    expSeq++;
    for (int i = 0; i < n; i++) begin
      b = gotQ.pop_front();
      checkOutput("payload_data", b[31:0], base + 32'(i));
      checkOutput("payload_last", 32'(b[32]), 32'(i == n - 1));
    end
  endtask

  initial begin
    int early;
    int stallErr;
    logic wasStall;
    logic [31:0] prevData;
    logic prevLast;

    rst = 1'b1;
    trade_valid = 1'b0;
    trade_info = 32'h0;
    m_tready = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_tvalid", 32'(m_tvalid), 32'd0);
    checkOutput("rst_tdata", m_tdata, 32'h0);
    checkOutput("rst_tlast", 32'(m_tlast), 32'd0);
    checkOutput("rst_overflow", 32'(overflow), 32'd0);
    checkOutput("rst_drop_count", 32'(drop_count), 32'd0);
    rst = 1'b0;

    // Full packet with a ready sink.
    $display("[TB] full packet");
    doReset();
    m_tready = 1'b1;
    applyStimulus(16, 32'h1);
    waitBeats("full_beats", 17 + SEQW, 200);
    checkPacket(16, 32'h1);

    // Timeout flush of a short packet.
    $display("[TB] timeout flush");
    doReset();
    m_tready = 1'b1;
    applyStimulus(3, 32'h1);
    early = 0;
    repeat (1021) begin
      @(negedge clk);
      if (m_tvalid) early++;
    end
    checkOutput("flush_early", 32'(early), 32'd0);
    @(negedge clk);
    checkOutput("flush_tvalid", 32'(m_tvalid), 32'd1);
    checkOutput("flush_hdr", m_tdata, 32'hC3000003);
    waitBeats("flush_beats", 4 + SEQW, 100);
    checkPacket(3, 32'h1);

    // Toggling ready: no loss, duplication or change while stalled.
    $display("[TB] toggling ready");
    doReset();
    m_tready = 1'b0;
    applyStimulus(16, 32'h100);
    stallErr = 0;
    wasStall = 1'b0;
    prevData = '0;
    prevLast = 1'b0;
    for (int i = 0; i < 300 && gotQ.size() < 17 + SEQW; i++) begin
      @(negedge clk);
      if (wasStall && (!m_tvalid || m_tdata !== prevData || m_tlast !== prevLast))
        stallErr++;
      m_tready = i[0];
      wasStall = m_tvalid && !m_tready;
      prevData = m_tdata;
      prevLast = m_tlast;
    end
    m_tready = 1'b1;
    checkOutput("stall_hold", 32'(stallErr), 32'd0);
    checkPacket(16, 32'h100);

    // Overflow with the sink stalled, then drain the oldest 64 words.
    $display("[TB] overflow");
    doReset();
    m_tready = 1'b0;
    applyStimulus(70, 32'h1);
    checkOutput("ovf_flag", 32'(overflow), 32'd1);
    checkOutput("ovf_drop_count", 32'(drop_count), 32'd6);
    m_tready = 1'b1;
    waitBeats("ovf_beats", 4 * (17 + SEQW), 500);
    for (int p = 0; p < 4; p++) checkPacket(16, 32'(1 + 16 * p));
    repeat (1200) @(negedge clk);
    checkOutput("ovf_no_extra", 32'(gotQ.size()), 32'd0);

    // Reset in the middle of a packet (drop_count is still 6 here).
    $display("[TB] mid-packet reset");
    gotQ.delete();
    applyStimulus(16, 32'h200);
    waitBeats("mid_beats", 5 + SEQW, 200);
    checkOutput("mid_tlast_seen", 32'(gotQ.size() > 0 ? gotQ[gotQ.size()-1][32] : 1'b0), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("mid_tvalid", 32'(m_tvalid), 32'd0);
    checkOutput("mid_tlast", 32'(m_tlast), 32'd0);
    checkOutput("mid_drop_count", 32'(drop_count), 32'd0);
    checkOutput("mid_overflow", 32'(overflow), 32'd0);
    rst = 1'b0;
    gotQ.delete();
    expSeq = 0;
    repeat (1200) @(negedge clk);
    checkOutput("mid_stale", 32'(gotQ.size()), 32'd0);

`ifdef PKT_SEQ_EN
    // Two full packets carry sequence numbers 0 and 1.
    $display("[TB] sequence numbers");
    doReset();
    m_tready = 1'b1;
    applyStimulus(32, 32'h300);
    waitBeats("seq_beats", 36, 300);
    checkPacket(16, 32'h300);
    checkPacket(16, 32'h310);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/trade_report_packetizer.md
TRADE_REPORT_PACKETIZER -- requirements
Module: trade_report_packetizer

Interface
REQ-001 SHALL have parameter MAX_WORDS, default 16, meaning the maximum number of payload words per packet (1..255).
REQ-002 SHALL have parameter FIFO_DEPTH, default 64, meaning the buffer depth in words (power of two, at least MAX_WORDS).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning the idle-flush timeout in clk cycles (at least 1).
REQ-004 clk  in  1  sole clock; all logic on the rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 trade_valid  in  1  one-cycle strobe qualifying trade_info; no backpressure toward the source.
REQ-007 trade_info  in  32  trade report or dump word from the order book.
REQ-008 m_tvalid  out  1  stream word valid toward the UDP transmit path.
REQ-009 m_tdata  out  32  stream word.
REQ-010 m_tlast  out  1  marks the final word of a packet.
REQ-011 m_tready  in  1  downstream accept.
REQ-012 overflow  out  1  sticky flag; set when a word is dropped.
REQ-013 drop_count  out  16  count of dropped words; saturates at 16'hFFFF.

Function
REQ-014 SHALL write trade_info into a FIFO on every trade_valid cycle in which FIFO level < FIFO_DEPTH at the start of that cycle, independent of a same-cycle read.
REQ-015 SHALL otherwise drop the word, set overflow, and increment drop_count, saturating at 16'hFFFF.
REQ-016 SHALL implement FSM states IDLE, HDR, SEQ, PAYLOAD.
REQ-017 IDLE -> HDR when level >= MAX_WORDS, or when level > 0 and flush_timer == TIMEOUT_CYCLES-1.
REQ-018 On the IDLE -> HDR transition, SHALL latch pkt_len = min(level, MAX_WORDS).
REQ-019 flush_timer SHALL count only in IDLE while level > 0, and SHALL clear to 0 when level == 0 or on leaving IDLE.
REQ-020 HDR SHALL drive m_tdata = {8'hC3, 8'h00, 8'd0, pkt_len[7:0]} with m_tvalid=1 and m_tlast=0, in the cycle after the trigger.
REQ-021 HDR SHALL advance on handshake (m_tvalid && m_tready) to SEQ if the sequence feature is enabled, else to PAYLOAD.
REQ-022 PAYLOAD SHALL emit exactly pkt_len FIFO words in order, one per handshake.
REQ-023 SHALL assert m_tlast on the pkt_len-th payload word, then return to IDLE.
REQ-024 While m_tvalid=1 and m_tready=0, SHALL hold m_tdata and m_tlast stable; m_tvalid SHALL NOT deassert before the handshake.
REQ-025 Back-to-back packets SHALL be possible, with a minimum of one IDLE cycle between the m_tlast handshake and the next header.
REQ-026 Words arriving during a packet SHALL remain queued for later packets and never alter the current pkt_len.
REQ-027 m_tvalid SHALL be 0 in IDLE; m_tlast SHALL be 0 outside the final payload word.
REQ-028 FIFO pointers SHALL wrap modulo FIFO_DEPTH; level SHALL be tracked with log2(FIFO_DEPTH)+1 bits.

Reset
REQ-029 rst SHALL force m_tvalid=0, m_tdata=0, m_tlast=0, overflow=0, drop_count=0, state=IDLE, FIFO empty, flush_timer=0, seq_num=0.
REQ-030 rst asserted mid-packet SHALL abort the packet without asserting m_tlast and SHALL discard queued words.

Configuration
REQ-031 Macro PKT_SEQ_EN defined: SEQ state SHALL emit one word = 32-bit seq_num after the header; seq_num SHALL increment by one on each m_tlast handshake and wrap at 2^32.
REQ-032 Macro PKT_SEQ_EN undefined: the SEQ state and seq_num SHALL NOT exist, and packets SHALL contain only the header plus payload.

Structure
REQ-033 The shared defines file SHALL hold the header magic 8'hC3 and the FSM state encodings.
REQ-034 SHALL instantiate one sub-module, sync_fifo (32-bit, FIFO_DEPTH, registered read, level output).

Verification
REQ-035 With m_tready=1, 16 strobes 0x00000001..0x00000010 -> header 0xC3000010, then 16 words in order, m_tlast on 0x00000010.
REQ-036 3 strobes, then none for 1024 cycles -> header 0xC3000003 and 3 words; no output before flush_timer reaches 1023.
REQ-037 m_tready toggled 0/1 each cycle during a 16-word packet -> no word lost, duplicated, or changed while stalled.
REQ-038 m_tready=0 with 70 strobes -> 64 words buffered, overflow=1, drop_count=6; the oldest 64 words are emitted after m_tready=1.
REQ-039 With PKT_SEQ_EN defined, two full packets -> second word 0x00000000 in the first packet and 0x00000001 in the second.
REQ-040 rst asserted at payload word 5 of 16 -> next cycle m_tvalid=0, drop_count=0; after release, no stale words are emitted.
